// File: rtl/simple_dual_ram_ex_pkg.sv
// Shared types and helpers for simple_dual_ram_ex: FSM state, mask lane count, lane merge.
package simple_dual_ram_ex_pkg;

  localparam int unsigned MAX_W = 256;
  localparam int unsigned MAX_B = 32;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  function automatic int unsigned calc_bytes(input int unsigned size);
    return (size + 7) / 8;
  endfunction

  // Lanes with mask bit set take new_w, the rest keep old_w.
  function automatic logic [MAX_W-1:0] lane_merge(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_B-1:0] mask);
    logic [MAX_W-1:0] res;
    for (int unsigned i = 0; i < MAX_B; i++)
      res[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/simple_dual_ram_ex_core.sv
// Bare storage array: one write port with per-byte lane enables, one registered read port.
module simple_dual_ram_ex_core #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [SIZE-1:0]            wdata,
  input  logic [(SIZE+7)/8-1:0]      wmask,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [SIZE-1:0]            rdata
);

  logic [SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < SIZE; b++)
        if (wmask[b/8]) mem[waddr][b] <= wdata[b];
    end
  end

  // Read-first: a same-cycle write to raddr is not seen here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/simple_dual_ram_ex.sv
// Simple dual-port RAM with byte masks, read-valid and a clear engine that initialises every entry.
// Define SIMPLE_DUAL_RAM_EX_BYPASS_EN for write-first collisions; default is read-first.
module simple_dual_ram_ex
  import simple_dual_ram_ex_pkg::*;
#(
  parameter int unsigned     SIZE       = 8,
  parameter int unsigned     DEPTH      = 8,
  parameter logic [SIZE-1:0] INIT_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  output logic                       busy,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [SIZE-1:0]            write_data,
  input  logic [calc_bytes(SIZE)-1:0] write_mask,
  input  logic                       write_en,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  input  logic                       read_en,
  output logic [SIZE-1:0]            read_data,
  output logic                       read_valid
);

  localparam int unsigned   AW    = $clog2(DEPTH);
  localparam int unsigned   BYTES = calc_bytes(SIZE);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic            ready;
  logic            wr_ok;
  logic            rd_ok;
  logic            rd_oor_q;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [SIZE-1:0] mem_wdata;
  logic [BYTES-1:0] mem_wmask;
  logic [SIZE-1:0] mem_rdata;

  assign ready = (state == ST_READY);
  assign wr_ok = ready && write_en && (32'(waddr) < DEPTH);
  assign rd_ok = ready && read_en && (32'(raddr) < DEPTH);

  // The clear engine owns the write port for the whole CLEAR state.
  always_comb begin
    mem_we    = wr_ok;
    mem_waddr = waddr;
    mem_wdata = write_data;
    mem_wmask = write_mask;
    if (!ready) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wdata = INIT_VALUE;
      mem_wmask = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == LAST) begin
            state   <= ST_READY;
            busy    <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        ST_READY: begin
          if (clear) begin
            state   <= ST_CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          busy    <= 1'b1;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  // Out-of-range flag only changes on an accepted read so read_data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_valid <= 1'b0;
      rd_oor_q   <= 1'b0;
    end else begin
      read_valid <= ready && read_en;
      if (ready && read_en) rd_oor_q <= !rd_ok;
    end
  end

  simple_dual_ram_ex_core #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .wmask (mem_wmask),
    .re    (rd_ok),
    .raddr (raddr),
    .rdata (mem_rdata)
  );

`ifdef SIMPLE_DUAL_RAM_EX_BYPASS_EN
  logic             byp_q;
  logic [SIZE-1:0]  byp_data_q;
  logic [BYTES-1:0] byp_mask_q;

  // The core returns the old word; the captured write lanes are merged over it one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      byp_mask_q <= '0;
    end else if (ready && read_en) begin
      byp_q      <= rd_ok && wr_ok && (waddr == raddr);
      byp_data_q <= write_data;
      byp_mask_q <= write_mask;
    end
  end

  always_comb begin
    if (rd_oor_q)   read_data = '0;
    else if (byp_q) read_data = SIZE'(lane_merge(MAX_W'(mem_rdata), MAX_W'(byp_data_q),
                                                 MAX_B'(byp_mask_q)));
    else            read_data = mem_rdata;
  end
`else
  assign read_data = rd_oor_q ? '0 : mem_rdata;
`endif

endmodule

// File: doc/simple_dual_ram_ex.md
# simple_dual_ram_ex

Parametrised single-clock simple dual-port RAM with per-byte write masks, read-valid signalling, a hardware clear engine that initialises every entry after reset or on request, and defined read/write collision behaviour. It is the general storage block behind framebuffers, guess/score history tables and FIFOs in the game logic. It replaces ad-hoc RAM instances wherever initialised contents or partial-word writes are needed.

## Interface
- SIZE, 8, word width in bits, 1..256; BYTES = ceil(SIZE/8) mask lanes, last lane partial if SIZE%8≠0
- DEPTH, 8, number of entries, 2..65536, need not be a power of two; AW = $clog2(DEPTH)
- INIT_VALUE, 0, SIZE-bit value written to every entry by the clear engine
- clk  input  1  sole clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- clear  input  1  pulse in READY starts a full re-initialisation
- busy  output  1  1 while clear engine runs
- waddr  input  AW  write address
- write_data  input  SIZE  write data
- write_mask  input  BYTES  per-byte lane enable, bit i covers bits [8i+7:8i]
- write_en  input  1  write strobe
- raddr  input  AW  read address
- read_en  input  1  read strobe
- read_data  output  SIZE  read result
- read_valid  output  1  read_data is a new result this cycle

## Operation
- Two states: CLEAR, READY. Reset → CLEAR, clear counter = 0.
- CLEAR: one entry per cycle written with INIT_VALUE (all lanes), counter 0..DEPTH-1; after writing DEPTH-1 → READY. busy=1 throughout, including while rst_n low.
- READY: busy=0. clear=1 → CLEAR next cycle, counter 0. clear in CLEAR ignored (no restart).
- In CLEAR, write_en and read_en ignored: no user write, read_valid stays 0, read_data holds.
- Write (READY): write_en=1 and waddr<DEPTH → lanes with mask bit 1 updated, others unchanged. mask all 0 → no change. waddr≥DEPTH → dropped.
- Read (READY): read_en=1 → read_data and read_valid=1 next cycle. raddr≥DEPTH → read_data=0, read_valid=1. read_en=0 → read_valid=0, read_data holds last value.
- Collision (same cycle write_en, read_en, waddr==raddr<DEPTH): behaviour per Configuration; always deterministic.
- Reset mid-clear or mid-read: clear restarts at 0; pending read discarded. Memory contents not reset directly; only the clear engine overwrites them.

## Timing
- Reset values: read_data=0, read_valid=0, busy=1.
- First READY cycle after rst_n deassert: cycle DEPTH (deassert edge = cycle 0 with first clear write).
- clear pulse at cycle N → busy=1 at N+1 .. N+DEPTH, busy=0 at N+DEPTH+1.
- Read latency 1 cycle; throughput one read and one write per cycle.
- Write at cycle N visible to reads issued at N+1 onward.

## Configuration
- SIMPLE_DUAL_RAM_EX_BYPASS_EN defined: collision is write-first; read_data = stored word with masked lanes replaced by write_data.
- Not defined: collision is read-first; read_data = old stored word. Bypass mux and address comparator absent.

## Structure
- Package simple_dual_ram_ex_pkg: state enum {ST_CLEAR, ST_READY}, function for BYTES from SIZE, lane-merge function (old, new, mask).
- Sub-module simple_dual_ram_ex_core: bare storage array, one write port with per-lane enable, one registered read port; top holds FSM, clear counter, address range checks, bypass, valid logic.

## Test plan
- SIZE=16, DEPTH=8, INIT_VALUE=16'hA5A5: release reset → busy=1 for 8 cycles; read all 8 addresses → each 16'hA5A5, read_valid=1 one cycle after each read_en.
- Write addr 3 data 16'h1234 mask 2'b10 → read addr 3 returns 16'h12A5; mask 2'b00 → unchanged.
- Same-cycle write addr 5 16'hBEEF mask 2'b11 and read addr 5 → 16'hBEEF with macro, 16'hA5A5 without.
- DEPTH=5: write addr 6 dropped, read addr 6 → 0 with read_valid=1; write/read addr 4 work.
- After writes, pulse clear → busy 8 cycles, writes/reads during CLEAR ignored (read_valid=0), afterwards all entries 16'hA5A5.
- Assert rst_n low at clear counter 3 → busy stays 1, read_valid=0; after release busy lasts full DEPTH cycles.
